// File: rtl/serdes_pkg.sv
// Shared constants and types for the serdes transmit/receive stream blocks.
package serdes_pkg;

    localparam int unsigned SERDES_LOGIC_SIZE = 8;
    localparam int unsigned SERDES_PKT_BEATS  = 16;

    // Beat index width; a single-beat packet still needs a 1-bit index.
    function automatic int unsigned beat_width(input int unsigned beats);
        return (beats > 1) ? unsigned'($clog2(beats)) : 1;
    endfunction

    localparam int unsigned SERDES_BEAT_W = beat_width(SERDES_PKT_BEATS);

    typedef logic [SERDES_BEAT_W-1:0] beat_idx_t;

endpackage

// File: rtl/hold_buf2.sv
// Two-entry register FIFO: push, pop, head data and occupancy; no flow control.
module hold_buf2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_axis_source.sv
// Drains the async FIFO read port into an AXI-Stream master with tlast framing.
module fifo_axis_source
    import serdes_pkg::*;
#(
    parameter int unsigned LOGIC_SIZE = SERDES_LOGIC_SIZE,
    parameter int unsigned PKT_BEATS  = SERDES_PKT_BEATS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rempty,
    output logic                  o_rr,
    input  logic [LOGIC_SIZE-1:0] i_rdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic [LOGIC_SIZE-1:0] o_tdata,
    output logic                  o_tlast,
    output logic                  o_idle
);

    localparam int unsigned BW = beat_width(PKT_BEATS);

    logic [1:0]    count;
    logic          inflight;
    logic [BW-1:0] beat;
    logic          pop;
    logic [2:0]    occupancy;

    hold_buf2 #(
        .WIDTH (LOGIC_SIZE)
    ) u_buf (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (inflight),
        .pop   (pop),
        .din   (i_rdata),
        .head  (o_tdata),
        .count (count)
    );

    assign o_tvalid = (count != 2'd0);
    assign pop      = o_tvalid && i_tready;

    // Slots committed after this cycle's pop; the ready path is what keeps one beat per cycle.
    always_comb begin
        occupancy = 3'(count) + 3'(inflight) - 3'(pop);
        o_rr      = !i_rempty && (occupancy < 3'd2);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            inflight <= 1'b0;
            beat     <= '0;
        end else begin
            inflight <= o_rr;
            if (pop) begin
                beat <= (beat == BW'(PKT_BEATS - 1)) ? '0 : beat + BW'(1);
            end
        end
    end

    assign o_tlast = o_tvalid && (beat == BW'(PKT_BEATS - 1));
    assign o_idle  = (count == 2'd0) && !inflight;

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        (3'(count) + 3'(inflight)) <= 3'd2);

endmodule

// File: doc/fifo_axis_source.md
# fifo_axis_source

Read-side drain for the async FIFO. It issues read requests against the FIFO read port, absorbs the FIFO's one-cycle read latency in a 2-entry holding buffer, and presents the words as an AXI-Stream master with packet framing on `o_tlast`. It sits in the FIFO's read clock domain and feeds the downstream serializer/stream logic at up to one beat per cycle.

## Interface
**Parameters**
- `LOGIC_SIZE`, default 8: word width in bits. Must match the FIFO.
- `PKT_BEATS`, default 16: beats per packet. Must be ≥1; `o_tlast` marks the last beat of each packet.

**Ports**
- `i_clk`, input, 1: single clock; the same clock as the FIFO read clock.
- `i_rst`, input, 1: reset, asynchronous, active-high.
- `i_rempty`, input, 1: FIFO empty flag.
- `o_rr`, output, 1: FIFO read request.
- `i_rdata`, input, `LOGIC_SIZE`: FIFO read data, valid the cycle after an accepted request.
- `o_tvalid`, output, 1: AXI-Stream valid.
- `i_tready`, input, 1: AXI-Stream ready.
- `o_tdata`, output, `LOGIC_SIZE`: AXI-Stream data.
- `o_tlast`, output, 1: last beat of a packet.
- `o_idle`, output, 1: high when nothing is buffered and nothing is in flight.

## Operation
**State**
- `count` (0..2): entries held in the holding buffer.
- `inflight` (0..1): a read was accepted last cycle and its data arrives on `i_rdata` this cycle.
- `beat` (0..`PKT_BEATS`-1): position within the current packet.

**Derived signals**
- `pop = o_tvalid && i_tready`.
- `o_rr = !i_rempty && (count + inflight - pop) < 2`. This is combinational from `i_tready` and `i_rempty`; the path is intentional and is what allows full throughput.
- An accepted read is `o_rr && !i_rempty` at a rising edge. It sets `inflight` to 1 for the next cycle; otherwise `inflight` is 0.

**Buffer behaviour**
- When `inflight` is 1, `i_rdata` is written into the buffer tail at the end of that cycle.
- The buffer is FIFO-ordered.
- The head entry drives `o_tdata`, and `o_tvalid = (count != 0)`.
- A simultaneous capture and pop leaves `count` unchanged and advances the head.
- Overflow is impossible by construction. Assert `count + inflight <= 2` in simulation.

**Packet framing**
- `o_tlast = o_tvalid && (beat == PKT_BEATS-1)`.
- `beat` increments on `pop` and wraps from `PKT_BEATS`-1 to 0.
- With `PKT_BEATS`=1, `o_tlast` equals `o_tvalid`.

**Other rules**
- `o_idle = (count == 0) && !inflight`.
- AXI-Stream rules hold: once `o_tvalid` is high it stays high and `o_tdata`/`o_tlast` stay stable until `pop`.
- Reset mid-operation:
  - `count`, `inflight` and `beat` clear immediately.
  - Buffered words and an in-flight word are discarded. The FIFO has already popped them, so they are lost.
  - The next packet starts at `beat` 0.

## Timing
**Reset values:** `o_rr`=0 while `i_rempty`=1, `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `o_idle`=1.

**Latency**, with an empty buffer and `i_rempty` falling in cycle k:
- `o_rr`=1 in cycle k.
- `i_rdata` is valid in cycle k+1.
- `o_tvalid`=1 from cycle k+2.

**Throughput:** with `i_tready` held high and the FIFO non-empty, one beat per cycle is sustained (`count`=1, `inflight`=1 steady state).

**Backpressure:** with `i_tready` low, at most 2 words are requested beyond the last pop, then `o_rr` drops.

**Release:** when `i_tready` rises with `count`=2, `o_rr` reasserts in that same cycle.

## Structure
- **Package `serdes_pkg`:** holds the `beat_idx_t` typedef (`$clog2(PKT_BEATS)` bits, minimum 1) and the default constants `SERDES_LOGIC_SIZE`=8 and `SERDES_PKT_BEATS`=16, which are shared with the transmit/serializer blocks.
- **Sub-module `hold_buf2`:** a 2-entry register FIFO with push, pop, head data and count. It has no flow-control logic. `fifo_axis_source` owns the read-request, in-flight and framing logic.

## Test plan
- **Reset and idle:** assert `i_rst` with `i_rempty`=1 → `o_tvalid`=0, `o_rr`=0, `o_idle`=1; release → no change.
- **Single word:** `i_rempty` falls at cycle 0 and rises again after one accepted read, with `i_rdata`=0xA5 at cycle 1 → `o_tvalid`=1 with `o_tdata`=0xA5 at cycle 2, `o_tlast`=0; after pop, `o_idle`=1.
- **Streaming:** 32 words 0x00..0x1F, `i_tready`=1, `PKT_BEATS`=16 → 32 consecutive beats in order, `o_tlast` on 0x0F and 0x1F, no bubbles after the first beat.
- **Backpressure:** `i_tready`=0 for 10 cycles mid-stream → exactly 2 words buffered, `o_rr`=0, `o_tdata` stable; `i_tready`=1 → `o_rr` high in the same cycle, no loss or duplication.
- **Random stall:** 50% random `i_tready` and `i_rempty` over 1000 words → scoreboard in-order match, `o_tlast` every 16th beat, buffer assertion never fires.
- **Reset mid-packet:** pulse `i_rst` after beat 5 with 2 words buffered → `o_tvalid` drops immediately; the next delivered word starts at `beat` 0, with `o_tlast` after 16 beats.
